cache_wbuf: RTL

- Posted write buffer between the cache's main-memory port (upstream) and the main memory (downstream).
- Cache writes, both write-backs and MMIO, are absorbed into a FIFO and acknowledged in one cycle. The buffer then drains them to memory in order.
- Reads hold until the buffer is empty, so read-after-write is always coherent.
- Writes to the same word as the FIFO tail are merged, cutting memory write traffic.

---
 rtl/cache_wbuf.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_wbuf.sv
// cache_wbuf: posted write buffer between the cache's memory port (upstream)
// and main memory (downstream).
//   - Writes (up_wstrb != 0) are absorbed into a DEPTH-entry FIFO and
//     acknowledged with a one-cycle up_ready pulse. A write to the same word
//     as the FIFO tail is merged into it, unless the tail is the entry that is
//     being presented downstream.
//   - The FIFO drains in order. Each transaction holds dn_valid until
//     dn_ready, and dn_valid is then low for at least one cycle.
//   - Reads (up_wstrb == 0) wait until the FIFO is empty and memory is idle.
//     They are then issued downstream, and the returned data is presented on
//     up_rdata with up_ready.
// Ports:
//   clk, resetn              clock and synchronous active-low reset
//   up_valid/addr/wdata/wstrb  request from the cache, held until up_ready
//   up_ready, up_rdata       one-cycle completion pulse, read data
//   dn_valid/addr/wdata/wstrb  request to memory, word-aligned address
//   dn_ready, dn_rdata       one-cycle completion pulse from memory, read data
//   count, empty, full       FIFO occupancy
// All outputs are registered.
module cache_wbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   up_valid,
    input  logic [ADDR_W-1:0]      up_addr,
    input  logic [31:0]            up_wdata,
    input  logic [3:0]             up_wstrb,
    output logic                   up_ready,
    output logic [31:0]            up_rdata,
    output logic                   dn_valid,
    output logic [ADDR_W-1:0]      dn_addr,
    output logic [31:0]            dn_wdata,
    output logic [3:0]             dn_wstrb,
    input  logic                   dn_ready,
    input  logic [31:0]            dn_rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_GAP,
        S_RD_ISSUE,
        S_RD_RESP
    } state_t;

    state_t            r_state;

    // FIFO storage: word address, data, byte enables
    logic [WA_W-1:0]   r_mem_addr [DEPTH];
    logic [31:0]       r_mem_data [DEPTH];
    logic [3:0]        r_mem_strb [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;

    logic              r_up_ready;
    logic [31:0]       r_up_rdata;
    logic              r_dn_valid;
    logic [ADDR_W-1:0] r_dn_addr;
    logic [31:0]       r_dn_wdata;
    logic [3:0]        r_dn_wstrb;

    logic [PTR_W-1:0]  w_tail;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_tail_busy;
    logic              w_merge;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_unused_addr;

    // Byte-offset bits of the upstream address are not used.
    assign w_unused_addr = ^up_addr[1:0];

    always_comb begin
        w_tail   = r_wptr - PTR_W'(1);
        // up_valid is ignored while up_ready is high, so a held request
        // cannot be accepted twice.
        w_wr_req = up_valid && (up_wstrb != 4'h0) && !r_up_ready;
        w_rd_req = up_valid && (up_wstrb == 4'h0) && !r_up_ready;
        // With a single entry, the tail is also the head. In IDLE the head is
        // about to be copied into the dn_* registers, and in DRAIN it is
        // already there. A merge at that point would be lost, so it is blocked.
        w_tail_busy = (r_count == CNT_W'(1)) &&
                      ((r_state == S_IDLE) || (r_state == S_DRAIN));
        w_merge  = w_wr_req && !r_empty && !w_tail_busy &&
                   (up_addr[ADDR_W-1:2] == r_mem_addr[w_tail]);
        w_push   = w_wr_req && !w_merge && !r_full;
        w_pop    = (r_state == S_DRAIN) && dn_ready;

        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // FIFO storage. The contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= up_addr[ADDR_W-1:2];
            r_mem_data[r_wptr] <= up_wdata;
            r_mem_strb[r_wptr] <= up_wstrb;
        end else if (w_merge) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (up_wstrb[b]) begin
                    r_mem_data[w_tail][b*8 +: 8] <= up_wdata[b*8 +: 8];
                end
            end
            r_mem_strb[w_tail] <= r_mem_strb[w_tail] | up_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_up_ready <= 1'b0;
            r_up_rdata <= '0;
            r_dn_valid <= 1'b0;
            r_dn_addr  <= '0;
            r_dn_wdata <= '0;
            r_dn_wstrb <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));

            // Write completion. The read path below overrides this when its data returns.
            r_up_ready <= w_push || w_merge;

            case (r_state)
                S_IDLE: begin
                    if (!r_empty) begin
                        // Draining takes priority over a pending read.
                        r_state    <= S_DRAIN;
                        r_dn_valid <= 1'b1;
                        r_dn_addr  <= {r_mem_addr[r_rptr], 2'b00};
                        r_dn_wdata <= r_mem_data[r_rptr];
                        r_dn_wstrb <= r_mem_strb[r_rptr];
                    end else if (w_rd_req) begin
                        r_state    <= S_RD_ISSUE;
                        r_dn_valid <= 1'b1;
                        r_dn_addr  <= {up_addr[ADDR_W-1:2], 2'b00};
                        r_dn_wdata <= '0;
                        r_dn_wstrb <= '0;
                    end
                end
                S_DRAIN: begin
                    if (dn_ready) begin
                        r_dn_valid <= 1'b0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    if (dn_ready) begin
                        r_dn_valid <= 1'b0;
                        r_up_rdata <= dn_rdata;
                        r_up_ready <= 1'b1;
                        r_state    <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign up_ready = r_up_ready;
    assign up_rdata = r_up_rdata;
    assign dn_valid = r_dn_valid;
    assign dn_addr  = r_dn_addr;
    assign dn_wdata = r_dn_wdata;
    assign dn_wstrb = r_dn_wstrb;
    assign count    = r_count;
    assign empty    = r_empty;
    assign full     = r_full;

endmodule
